// File: rtl/gray_counter_n.sv
`timescale 1ns/1ps
// gray_counter_n
//   N-bit up/down counter that presents its value both in binary and in Gray
//   code. It supports a synchronous parallel load and, selected by a
//   parameter, either wraps around or saturates at the ends. Terminal-count
//   and cascade-enable outputs let several stages be chained together.
//
//   Parameters
//     WIDTH    counter width, 2..16
//     WRAP     1 = wrap around at the ends, 0 = saturate (hold) at the ends
//     RST_VAL  binary value forced while r is high
//
//   Ports
//     clk   in   system clock, rising edge
//     r     in   asynchronous active-high reset
//     ce    in   count enable, one step per edge
//     up    in   direction, 1 = increment, 0 = decrement
//     ld    in   synchronous load strobe; has priority over ce
//     din   in   binary load value
//     Y     out  registered Gray count
//     B     out  registered binary count
//     TC    out  terminal count for the current direction (combinational)
//     CEO   out  cascade enable, ce & TC
module gray_counter_n #(
    parameter int               WIDTH   = 4,
    parameter int               WRAP    = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             r,
    input  logic             ce,
    input  logic             up,
    input  logic             ld,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] B,
    output logic             TC,
    output logic             CEO
);

    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic             at_max;
    logic             at_zero;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    assign at_max  = (cnt == MAX);
    assign at_zero = (cnt == '0);

    always_comb begin
        cnt_nxt = cnt;
        if (ld) begin
            cnt_nxt = din;
        end else if (ce) begin
            if (up) begin
                if (!at_max) begin
                    cnt_nxt = cnt + WIDTH'(1);
                end else if (WRAP != 0) begin
                    cnt_nxt = '0;
                end
            end else begin
                if (!at_zero) begin
                    cnt_nxt = cnt - WIDTH'(1);
                end else if (WRAP != 0) begin
                    cnt_nxt = MAX;
                end
            end
        end
    end

    // Y is a register of its own, fed from the next binary value, so the
    // Gray output never sees the decode glitches of the binary register.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            cnt <= RST_VAL;
            Y   <= to_gray(RST_VAL);
        end else begin
            cnt <= cnt_nxt;
            Y   <= to_gray(cnt_nxt);
        end
    end

    assign B   = cnt;
    // TC follows the live direction input, not the direction last counted.
    assign TC  = up ? at_max : at_zero;
    assign CEO = ce & TC;

endmodule

// File: tb/tb_gray_counter_n.sv
`timescale 1ns/1ps
module tb_gray_counter_n;

    typedef struct {
        logic       ld;
        logic       ce;
        logic       up;
        logic [3:0] din;
        logic [3:0] exp_b;
    } vec_t;

    typedef struct {
        logic [15:0] b;
        logic [15:0] y;
    } exp_t;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance: wrap mode, reset value 0
    logic       r0 = 1'b1, ce0 = 1'b0, up0 = 1'b1, ld0 = 1'b0;
    logic [3:0] din0 = 4'd0;
    logic [3:0] y0, b0;
    logic       tc0, ceo0;
    // saturate mode
    logic       r1 = 1'b1, ce1 = 1'b0, up1 = 1'b1, ld1 = 1'b0;
    logic [3:0] din1 = 4'd0;
    logic [3:0] y1, b1;
    logic       tc1, ceo1;
    // reset value 7
    logic       r2 = 1'b1, ce2 = 1'b0, up2 = 1'b1, ld2 = 1'b0;
    logic [3:0] din2 = 4'd0;
    logic [3:0] y2, b2;
    logic       tc2, ceo2;
    // two-stage cascade
    logic       rc = 1'b1, cas_ce = 1'b0, cas_up = 1'b1, cas_ld = 1'b0;
    logic [3:0] cas_din = 4'd0;
    logic [3:0] yl, bl, yh, bh;
    logic       tcl, ceol, tch, ceoh;

    gray_counter_n #(.WIDTH(4), .WRAP(1), .RST_VAL(4'd0)) u_dut0 (
        .clk(clk), .r(r0), .ce(ce0), .up(up0), .ld(ld0), .din(din0),
        .Y(y0), .B(b0), .TC(tc0), .CEO(ceo0));

    gray_counter_n #(.WIDTH(4), .WRAP(0), .RST_VAL(4'd0)) u_dut1 (
        .clk(clk), .r(r1), .ce(ce1), .up(up1), .ld(ld1), .din(din1),
        .Y(y1), .B(b1), .TC(tc1), .CEO(ceo1));

    gray_counter_n #(.WIDTH(4), .WRAP(1), .RST_VAL(4'd7)) u_dut2 (
        .clk(clk), .r(r2), .ce(ce2), .up(up2), .ld(ld2), .din(din2),
        .Y(y2), .B(b2), .TC(tc2), .CEO(ceo2));

    gray_counter_n #(.WIDTH(4), .WRAP(1), .RST_VAL(4'd0)) u_lo (
        .clk(clk), .r(rc), .ce(cas_ce), .up(cas_up), .ld(cas_ld), .din(cas_din),
        .Y(yl), .B(bl), .TC(tcl), .CEO(ceol));

    gray_counter_n #(.WIDTH(4), .WRAP(1), .RST_VAL(4'd0)) u_hi (
        .clk(clk), .r(rc), .ce(ceol), .up(cas_up), .ld(cas_ld), .din(cas_din),
        .Y(yh), .B(bh), .TC(tch), .CEO(ceoh));

    // bitwise Gray encoding: each bit is the XOR of a binary bit and its upper neighbour
    function automatic logic [15:0] g16(input logic [15:0] b, input int w);
        logic [15:0] g;
        g = '0;
        for (int i = 0; i < w; i++) begin
            if (i == w - 1) g[i] = b[i];
            else            g[i] = b[i] ^ b[i+1];
        end
        return g;
    endfunction

    function automatic int nxt(input int c, input bit ld, input bit ce, input bit up,
                               input int din, input bit wrap, input int w);
        int mx;
        mx = (1 << w) - 1;
        if (ld)  return din;
        if (!ce) return c;
        if (up)  return (c == mx) ? (wrap ? 0 : c) : c + 1;
        return (c == 0) ? (wrap ? mx : c) : c - 1;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int b, input int w);
        exp_t e;
        e.b = 16'(b);
        e.y = g16(16'(b), w);
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input string nm, input logic [15:0] ab, input logic [15:0] ay);
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got B=%0h Y=%0h", nm, ab, ay);
        end else begin
            e = sb.pop_front();
            chk({nm, "_B"}, ab, e.b);
            chk({nm, "_Y"}, ay, e.y);
        end
    endtask

    task automatic edge0(input string nm, input int exp_b);
        push(exp_b, 4);
        tick();
        pop_cmp(nm, 16'(b0), 16'(y0));
    endtask

    task automatic edge1(input string nm, input int exp_b);
        push(exp_b, 4);
        tick();
        pop_cmp(nm, 16'(b1), 16'(y1));
    endtask

    task automatic edge2(input string nm, input int exp_b);
        push(exp_b, 4);
        tick();
        pop_cmp(nm, 16'(b2), 16'(y2));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got t=%0t, required finish before it", $time);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       tbl[14];
        int         m0, mn;
        logic [3:0] yprev;

        tbl[0]  = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd15};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd14};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 4'd0,  4'd14};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 4'd0,  4'd15};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 4'd0,  4'd0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 4'd5,  4'd5};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 4'd12, 4'd12};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 4'd0,  4'd13};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd12};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 4'd15, 4'd15};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 4'd0,  4'd0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 4'd0,  4'd15};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 4'd0,  4'd0};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 4'd0,  4'd0};

        // reset state
        #12;
        chk("rst_B", 16'(b0), 16'd0);
        chk("rst_Y", 16'(y0), 16'd0);
        chk("rst_TC_up", 16'(tc0), 16'd0);
        up0 = 1'b0;
        #1;
        chk("rst_TC_dn", 16'(tc0), 16'd1);
        chk("rst_CEO", 16'(ceo0), 16'd0);
        up0 = 1'b1;
        tick();
        r0 = 1'b0;
        m0 = 0;

        // up-count with ce pulsing one clock in four
        for (int i = 0; i < 64; i++) begin
            ce0 = (i % 4 == 3);
            up0 = 1'b1;
            #1;
            chk("up_TC", 16'(tc0), 16'(m0 == 15));
            chk("up_CEO", 16'(ceo0), 16'(ce0 && m0 == 15));
            if (m0 == 15) chk("up_Y_max", 16'(y0), 16'b1000);
            mn = nxt(m0, 1'b0, ce0, 1'b1, 0, 1'b1, 4);
            yprev = y0;
            edge0("up", mn);
            if (ce0) chk("up_onebit", 16'($countones(yprev ^ y0)), 16'd1);
            m0 = mn;
        end

        // vector table from a fresh reset: down wrap, direction change, load priority
        ce0 = 1'b0;
        r0 = 1'b1;
        #2;
        r0 = 1'b0;
        m0 = 0;
        for (int i = 0; i < 14; i++) begin
            ld0  = tbl[i].ld;
            ce0  = tbl[i].ce;
            up0  = tbl[i].up;
            din0 = tbl[i].din;
            #1;
            chk("tbl_TC", 16'(tc0), 16'(up0 ? (m0 == 15) : (m0 == 0)));
            edge0("tbl", int'(tbl[i].exp_b));
            if (tbl[i].ld && tbl[i].din == 4'd12) chk("ld_prio_Y", 16'(y0), 16'b1010);
            m0 = int'(tbl[i].exp_b);
        end
        ld0 = 1'b0;

        // full descending cycle
        ce0 = 1'b1;
        up0 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mn = nxt(m0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 4);
            yprev = y0;
            edge0("down", mn);
            chk("down_onebit", 16'($countones(yprev ^ y0)), 16'd1);
            m0 = mn;
        end
        chk("down_cycle_B", 16'(b0), 16'd0);

        // asynchronous reset between edges
        ce0 = 1'b0;
        ld0 = 1'b1;
        din0 = 4'd9;
        edge0("ld9", 9);
        ld0 = 1'b0;
        ce0 = 1'b1;
        up0 = 1'b1;
        #1;
        r0 = 1'b1;
        #2;
        chk("arst_B", 16'(b0), 16'd0);
        chk("arst_Y", 16'(y0), 16'd0);
        chk("arst_TC", 16'(tc0), 16'd0);
        #3;
        r0 = 1'b0;
        ce0 = 1'b0;
        edge0("arst_hold", 0);
        ce0 = 1'b1;
        edge0("arst_step", 1);
        ce0 = 1'b0;

        // saturate mode
        r1 = 1'b0;
        ce1 = 1'b1;
        up1 = 1'b1;
        for (int i = 1; i <= 15; i++) edge1("sat_up", i);
        for (int i = 0; i < 3; i++) begin
            chk("sat_TC", 16'(tc1), 16'd1);
            chk("sat_CEO", 16'(ceo1), 16'd1);
            edge1("sat_hold", 15);
            chk("sat_Y", 16'(y1), 16'b1000);
        end
        up1 = 1'b0;
        #1;
        chk("sat_TC_rev", 16'(tc1), 16'd0);
        edge1("sat_rev", 14);
        chk("sat_rev_Y", 16'(y1), 16'b1001);
        ld1 = 1'b1;
        din1 = 4'd1;
        edge1("sat_ld", 1);
        ld1 = 1'b0;
        edge1("sat_dn", 0);
        chk("sat_lo_CEO", 16'(ceo1), 16'd1);
        edge1("sat_lo_hold", 0);
        ce1 = 1'b0;

        // non-zero reset value
        chk("rv_B", 16'(b2), 16'd7);
        chk("rv_Y", 16'(y2), 16'b0100);
        r2 = 1'b0;
        ce2 = 1'b1;
        up2 = 1'b1;
        edge2("rv_up", 8);
        edge2("rv_up", 9);
        #1;
        r2 = 1'b1;
        #2;
        chk("rv_arst_B", 16'(b2), 16'd7);
        chk("rv_arst_Y", 16'(y2), 16'b0100);
        #3;
        r2 = 1'b0;
        edge2("rv_restart", 8);
        ce2 = 1'b0;

        // two-stage cascade, 256 clocks for a full 8-bit period
        rc = 1'b0;
        cas_ce = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            tick();
            chk("cas_B", 16'({bh, bl}), 16'(i % 256));
            chk("cas_Y", 16'({yh, yl}), 16'({g16(16'((i % 256) >> 4), 4)} << 4 | g16(16'(i % 16), 4)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_counter_n.md
Name: gray_counter_n

Overview:
- Parametrised successor to the lab's fixed 4-bit Gray counter with clock enable and reset.
- N-bit Gray-code counter with:
  - up/down direction
  - synchronous parallel load
  - selectable wrap or saturate at the ends
  - terminal-count (TC) and cascade-enable (CEO) outputs for chaining stages
- Used as a glitch-free position/state counter, and as a counter stage where several stages are cascaded through CEO.

Parameters:
- WIDTH, 4: counter width in bits; legal range 2..16.
- WRAP, 1: 1 = wrap around at the ends; 0 = saturate (hold) at the ends.
- RST_VAL, 0: binary value loaded on reset, WIDTH bits, must be less than 2^WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- r  in  1  reset, asynchronous, active-high; forces the reset state immediately, independent of clk.
- ce  in  1  count enable; one count step per clk edge while high.
- up  in  1  direction: 1 = increment, 0 = decrement.
- ld  in  1  synchronous load strobe.
- din  in  WIDTH  binary value to load.
- Y  out  WIDTH  Gray-coded count, registered.
- B  out  WIDTH  binary count, registered.
- TC  out  1  terminal count, combinational from state and up.
- CEO  out  1  cascade enable: ce & TC.

Behaviour:
- State:
  - The binary register cnt is the only state.
  - Y is a separate register holding gray(cnt) = cnt ^ (cnt >> 1), updated on the same edge as cnt.
  - Y is never decoded combinationally from B; Y must be glitch-free.
- Reset:
  - While r = 1: cnt = RST_VAL and Y = gray(RST_VAL), asynchronously.
  - TC and CEO follow combinationally from that state.
  - While r = 1: ld, ce and clk edges are ignored.
  - Deassertion of r takes effect at the next clk edge; there is no partial step.
- Priority per rising edge, when r = 0:
  1. If ld = 1: cnt <= din and Y <= gray(din). ce and up are ignored, so a load overrides a count.
  2. Else if ce = 1 and up = 1:
     - cnt < MAX: cnt <= cnt + 1.
     - cnt = MAX: cnt <= 0 if WRAP = 1, else hold.
  3. Else if ce = 1 and up = 0:
     - cnt > 0: cnt <= cnt - 1.
     - cnt = 0: cnt <= MAX if WRAP = 1, else hold.
  4. Else: hold.
- MAX = 2^WIDTH - 1.
- Arithmetic is modulo 2^WIDTH in WIDTH bits; no carry-out port.
- Latency: one clk from a ce/ld sample to the new Y/B.
- TC:
  - TC = 1 when (up = 1 and cnt = MAX) or (up = 0 and cnt = 0).
  - TC depends on the current up value, not the last direction used.
  - Gray value of MAX: MSB = 1, all other bits = 0.
- CEO:
  - CEO = ce & TC.
  - It is high exactly in the cycle before the stage wraps, so a following stage advances once per full period of this stage.
  - In saturate mode CEO is still asserted while at an end with ce = 1. A cascade using saturation must gate CEO externally.
- Gray invariant:
  - Any single counting step changes exactly one bit of Y, including the wrap steps MAX->0 and 0->MAX.
  - Loads and resets may change any number of bits.
- Direction change: reversing up mid-count takes effect on the next counted edge; no dead cycle.
- Reset mid-operation: asserting r between edges immediately forces Y, B and TC to their reset values. The next counted step starts from RST_VAL.

Test Plan:
- Up-count wrap (WIDTH = 4, WRAP = 1, ce pulsing 1 of every 4 clks, up = 1):
  - Y steps 0000, 0001, 0011, 0010, 0110, ... , 1000, then 0000.
  - TC = 1 only while B = 15.
  - CEO is a single-clk pulse coincident with the ce pulse at B = 15.
  - Exactly one Y bit changes per step.
- Down-count wrap (up = 0, from reset):
  - First ce step: B 0 -> 15, Y 0000 -> 1000.
  - TC = 1 at B = 0 before that step.
  - Full descending cycle reaches B = 0 again after 16 steps.
- Saturate (WRAP = 0):
  - Count up to 15, then hold ce = 1 for 3 more clks: B stays 15, Y stays 1000, TC = 1, CEO = 1.
  - Set up = 0: TC drops the same cycle; the next edge gives B = 14, Y = 1001.
- Load priority:
  - At B = 5, drive ld = 1, din = 12 and ce = 1 on the same edge: B = 12, Y = 1010 (not 6).
  - Next ce edge, up = 1: B = 13, Y = 1011.
- Asynchronous reset mid-count:
  - Pulse r for 5 ns between clk edges at B = 9.
  - Y and B go to 0 within the pulse, before the next edge, and stay 0 until the first ce edge after r falls.
  - Repeat with RST_VAL = 7: Y = 0100.
- Cascade (two WIDTH = 4 instances, CEO of the first driving ce of the second, ce = 1 continuously):
  - The upper stage advances once per 16 clks.
  - The combined 8-bit binary count reaches 255, then returns to 0 after 256 clks.
